// File: rtl/score_scan_pkg.sv
// Purpose: shared constants, converter state type and helpers for the score display path.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package score_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [3:0]         BLANK_CODE = 4'hF;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 14'd9999;

  // Converter sequencing: wait for a score, run the double-dabble steps, publish.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  // Scores beyond four decimal digits saturate to the largest displayable value.
  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets 3 added before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3) with a one-deep pending slot.
// Latency: start in cycle T -> bcd_valid in cycle T+15 (14 shift steps + commit).
// Backpressure: none; starts while busy are held as pending (last one wins) and chained at commit.
module bin2bcd_seq
  import score_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] value,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd_out,
  output logic               bcd_valid
);

  conv_state_e        state;
  conv_state_e        nxt;
  logic [SCORE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj;
  logic [3:0]         step;
  logic               pend_vld;
  logic [SCORE_W-1:0] pend_val;
  logic               load_now;
  logic [SCORE_W-1:0] load_val;

  // A new conversion begins from IDLE on a strobe, or straight out of COMMIT when
  // another value is waiting; a strobe in the COMMIT cycle is newer than the pending one.
  assign load_now = ((state == IDLE) && start) ||
                    ((state == COMMIT) && (start || pend_vld));
  assign load_val = start ? clamp_score(value) : pend_val;
  assign acc_adj  = add3_nibbles(acc);
  assign bcd_out  = acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state: 14 SHIFT steps (step 0..13), then one COMMIT cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (step == 4'd13) nxt = COMMIT;
      COMMIT:  nxt = (start || pend_vld) ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs: busy covers the whole conversion, bcd_valid marks the publish cycle.
  always_comb begin
    busy      = 1'b0;
    bcd_valid = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      COMMIT:  begin
        busy      = 1'b1;
        bcd_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: load a fresh operand, or shift {acc, bin_sr} left after the add-3 correction.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr <= '0;
      acc    <= '0;
      step   <= '0;
    end else if (load_now) begin
      bin_sr <= load_val;
      acc    <= '0;
      step   <= '0;
    end else if (state == SHIFT) begin
      acc    <= {acc_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
      bin_sr <= {bin_sr[SCORE_W-2:0], 1'b0};
      step   <= step + 4'd1;
    end
  end

  // Pending slot: strobes during SHIFT overwrite it; COMMIT always consumes or discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else if ((state == SHIFT) && start) begin
      pend_vld <= 1'b1;
      pend_val <= clamp_score(value);
    end else if (state == COMMIT) begin
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/score_scan.sv
// Purpose: score to 4-digit multiplexed 7-seg feed (BCD conversion, leading-zero blanking, scan).
// Latency: load in T -> new value displayed from T+16; digit/an registered one cycle after scan index.
// Backpressure: none; loads while busy are queued one deep (last wins), scanning never stalls.
module score_scan
  import score_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_load,
  output logic               busy,
  output logic [3:0]         digit,
  output logic [3:0]         an
);

  localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

  logic [BCD_W-1:0] bcd;
  logic             bcd_valid;
  logic [BCD_W-1:0] disp;
  logic [15:0]      presc;
  logic [1:0]       scan_idx;
  logic [3:0]       nib;
  logic             blank;
  logic [3:0]       code;
  logic             d3z;
  logic             d2z;
  logic             d1z;

  bin2bcd_seq u_conv (
    .clk       (clk),
    .rst       (rst),
    .start     (score_load),
    .value     (score_in),
    .busy      (busy),
    .bcd_out   (bcd),
    .bcd_valid (bcd_valid)
  );

  // Displayed value only moves at commit, so the scan never shows a half-converted number.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
    end else if (bcd_valid) begin
      disp <= bcd;
    end
  end

  // Prescaler sets the dwell time per digit; each wrap advances the scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PRESC_LAST) begin
      presc    <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign d3z = (disp[15:12] == 4'd0);
  assign d2z = (disp[11:8]  == 4'd0);
  assign d1z = (disp[7:4]   == 4'd0);

  // Select the nibble for the current slot and blank it if it is a leading zero.
  always_comb begin
    nib   = disp[{scan_idx, 2'b00} +: 4];
    blank = 1'b0;
    case (scan_idx)
      2'd3:    blank = d3z;
      2'd2:    blank = d3z & d2z;
      2'd1:    blank = d3z & d2z & d1z;
      default: blank = 1'b0;
    endcase
    code = blank ? BLANK_CODE : nib;
  end

  // Register digit and anode together so the decoder never sees them skewed.
  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= 4'b1111;
      digit <= BLANK_CODE;
    end else begin
      an    <= 4'b1111 ^ (4'b0001 << scan_idx);
      digit <= code;
    end
  end

endmodule

// File: tb/tb_score_scan.sv
// Purpose: self-checking bench for score_scan with REFRESH_DIV=4 and an arithmetic display model.
// Latency: n/a.
// Backpressure: n/a.
module tb_score_scan;

  logic        clk;
  logic        rst;
  logic [13:0] score_in;
  logic        score_load;
  logic        busy;
  logic [3:0]  digit;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int e      = 0;   // clock edges since reset was last sampled

  score_scan #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .score_in   (score_in),
    .score_load (score_load),
    .busy       (busy),
    .digit      (digit),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) e <= 0;
    else     e <= e + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digit at slot s of the clamped score, leading zeros blanked to F.
  function automatic logic [3:0] model_digit(input int v, input int s);
    int vv;
    int p;
    vv = (v > 9999) ? 9999 : v;
    if (s == 3 && vv < 1000) return 4'hF;
    if (s == 2 && vv < 100)  return 4'hF;
    if (s == 1 && vv < 10)   return 4'hF;
    p = 1;
    for (int k = 0; k < s; k++) p = p * 10;
    return 4'((vv / p) % 10);
  endfunction

  task automatic load(input int v);
    score_in   = 14'(v);
    score_load = 1'b1;
    tick();
    score_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    chk(tag, {15'd0, busy}, 16'd0);
  endtask

  // One full scan (4 slots x 4 cycles): anode slot follows edges since reset, digit follows model.
  task automatic check_disp(input string tag, input int v);
    int slot;
    for (int i = 0; i < 16; i++) begin
      tick();
      slot = ((e - 1) / 4) % 4;
      chk({tag, "_an"}, {12'd0, an}, {12'd0, 4'b1111 ^ (4'b0001 << slot)});
      chk({tag, "_dig"}, {12'd0, digit}, {12'd0, model_digit(v, slot)});
    end
  endtask

  initial begin
    int v;
    rst        = 1'b1;
    score_in   = '0;
    score_load = 1'b0;

    // Reset held 3 cycles: all anodes off, blank code, converter idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", {12'd0, an}, 16'h000F);
      chk("rst_dig", {12'd0, digit}, 16'h000F);
      chk("rst_busy", {15'd0, busy}, 16'd0);
    end
    rst = 1'b0;
    check_disp("post_rst", 0);

    // 1234: busy high for exactly 15 cycles, then digits 4/3/2/1.
    load(1234);
    chk("busy_T1", {15'd0, busy}, 16'd1);
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk("busy_1234", {15'd0, busy}, (j < 15) ? 16'd1 : 16'd0);
    end
    check_disp("d1234", 1234);

    load(7);
    wait_idle("idle_7");
    check_disp("d7", 7);

    load(1005);
    wait_idle("idle_1005");
    check_disp("d1005", 1005);

    load(12000);
    wait_idle("idle_12000");
    check_disp("d12000", 12000);

    // 42, then 58 at T+5 and 77 at T+9: chained conversion, 58 never shown, ends at 77.
    load(42);
    for (int j = 1; j <= 30; j++) begin
      if (j == 5) begin
        score_in = 14'd58; score_load = 1'b1;
      end else if (j == 9) begin
        score_in = 14'd77; score_load = 1'b1;
      end else begin
        score_load = 1'b0;
      end
      tick();
      score_load = 1'b0;
      chk("busy_pend", {15'd0, busy}, (j < 30) ? 16'd1 : 16'd0);
      chk("no58", {15'd0, ((an == 4'b1110 && digit == 4'd8) || (an == 4'b1101 && digit == 4'd5))}, 16'd0);
    end
    check_disp("d77", 77);

    // 3210 aborted by reset at T+7: back to 0 and idle, then 55 converts normally.
    load(3210);
    for (int j = 1; j <= 6; j++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_an", {12'd0, an}, 16'h000F);
    chk("abort_dig", {12'd0, digit}, 16'h000F);
    rst = 1'b0;
    check_disp("d_abort", 0);
    load(55);
    wait_idle("idle_55");
    check_disp("d55", 55);

    // Random scores across the full 14-bit input range, including clamped ones.
    for (int r = 0; r < 8; r++) begin
      v = int'($urandom_range(0, 16383));
      load(v);
      wait_idle("idle_rand");
      check_disp("d_rand", v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
